audio_pcie_fifo_core: RTL and testbench

//  Width-converting FIFO between the audio path and the PCIe DMA path.

---
 rtl/audio_pcie_fifo_core.sv | 82 ++++++++
 tb/tb_audio_pcie_fifo_core.sv | 126 ++++++++++++
 2 files changed

// File: rtl/audio_pcie_fifo_core.sv
// audio_pcie_fifo_core: 16-bit in, 128-bit out width-converting FIFO for the audio-to-PCIe DMA path.
// Optional AUDIO_PCIE_FIFO_OUTPUT_REG_EN adds a second output register (read latency 2).
module audio_pcie_fifo_core #(
    parameter int WR_DEPTH_WIDTH   = 13,
    parameter int WR_DATA_WIDTH    = 16,
    parameter int RD_DEPTH_WIDTH   = 10,
    parameter int RD_DATA_WIDTH    = 128,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WR_DATA_WIDTH-1:0]   wr_data,
    input  logic                       wr_en,
    output logic                       wr_full,
    output logic [WR_DEPTH_WIDTH:0]    wr_water_level,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [RD_DATA_WIDTH-1:0]   rd_data,
    output logic                       rd_empty,
    output logic [RD_DEPTH_WIDTH:0]    rd_water_level,
    output logic                       almost_empty
);
    localparam int LB      = WR_DEPTH_WIDTH - RD_DEPTH_WIDTH;
    localparam int FULL_I  = 1 << WR_DEPTH_WIDTH;
    localparam int LANES_I = RD_DATA_WIDTH / WR_DATA_WIDTH;
    localparam logic [WR_DEPTH_WIDTH:0] FULL_LVL  = FULL_I[WR_DEPTH_WIDTH:0];
    localparam logic [WR_DEPTH_WIDTH:0] LANES_LVL = LANES_I[WR_DEPTH_WIDTH:0];
    localparam logic [WR_DEPTH_WIDTH:0] AF_LVL    = ALMOST_FULL_NUM[WR_DEPTH_WIDTH:0];
    localparam logic [RD_DEPTH_WIDTH:0] AE_LVL    = ALMOST_EMPTY_NUM[RD_DEPTH_WIDTH:0];

    logic [RD_DATA_WIDTH-1:0] mem [1 << RD_DEPTH_WIDTH];
    logic [WR_DEPTH_WIDTH:0]  wr_ptr, level, level_n;
    logic [RD_DEPTH_WIDTH:0]  rd_ptr;
    logic [RD_DATA_WIDTH-1:0] rd_q;
    logic                     wr_acc, rd_acc;

    assign wr_acc         = wr_en && !wr_full;
    assign rd_acc         = rd_en && !rd_empty;
    assign level_n        = level + (WR_DEPTH_WIDTH+1)'(wr_acc) - (rd_acc ? LANES_LVL : '0);
    assign wr_water_level = level;
    assign rd_water_level = level[WR_DEPTH_WIDTH:LB];

    // Flags are computed from the next level so they change on the same edge as the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
            rd_q         <= '0;
        end else begin
            wr_ptr       <= wr_ptr + (WR_DEPTH_WIDTH+1)'(wr_acc);
            rd_ptr       <= rd_ptr + (RD_DEPTH_WIDTH+1)'(rd_acc);
            level        <= level_n;
            wr_full      <= level_n == FULL_LVL;
            almost_full  <= level_n >= AF_LVL;
            rd_empty     <= level_n < LANES_LVL;
            almost_empty <= level_n[WR_DEPTH_WIDTH:LB] <= AE_LVL;
            if (rd_acc) rd_q <= mem[rd_ptr[RD_DEPTH_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr[WR_DEPTH_WIDTH-1:LB]][wr_ptr[LB-1:0]*WR_DATA_WIDTH +: WR_DATA_WIDTH] <= wr_data;
    end

`ifdef AUDIO_PCIE_FIFO_OUTPUT_REG_EN
    logic [RD_DATA_WIDTH-1:0] rd_q2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_q2 <= '0;
        else     rd_q2 <= rd_q;
    end
    assign rd_data = rd_q2;
`else
    assign rd_data = rd_q;
`endif
endmodule

// File: tb/tb_audio_pcie_fifo_core.sv
// tb_audio_pcie_fifo_core: scoreboard bench for audio_pcie_fifo_core (packing, fill, drain, flags, reset).
module tb_audio_pcie_fifo_core;
`ifdef AUDIO_PCIE_FIFO_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic         clk = 1'b0, rst = 1'b1;
    logic [15:0]  wr_data = '0;
    logic         wr_en = 1'b0, rd_en = 1'b0;
    logic         wr_full, almost_full, rd_empty, almost_empty;
    logic [13:0]  wr_water_level;
    logic [10:0]  rd_water_level;
    logic [127:0] rd_data;

    int           n_chk = 0, n_fail = 0, cyc = 0, mlevel = 0;
    logic [15:0]  sq[$];
    logic [127:0] exp_q[$];
    int           due_q[$];
    logic [127:0] last_exp = '0;

    audio_pcie_fifo_core dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
        .wr_water_level(wr_water_level), .almost_full(almost_full), .rd_en(rd_en),
        .rd_data(rd_data), .rd_empty(rd_empty), .rd_water_level(rd_water_level),
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_state();
        check("wr_level", 128'(wr_water_level), 128'(mlevel));
        check("rd_level", 128'(rd_water_level), 128'(mlevel / 8));
        check("wr_full", 128'(wr_full), 128'(mlevel == 8192));
        check("almost_full", 128'(almost_full), 128'(mlevel >= 1020));
        check("rd_empty", 128'(rd_empty), 128'(mlevel < 8));
        check("almost_empty", 128'(almost_empty), 128'(mlevel / 8 <= 4));
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r);
        logic [127:0] p;
        bit wa, ra;
        wr_en = w; wr_data = d; rd_en = r;
        wa = w && mlevel != 8192;
        ra = r && mlevel >= 8;
        if (ra) begin
            p = '0;
            for (int k = 0; k < 8; k++) p[16*k +: 16] = sq.pop_front();
            exp_q.push_back(p);
            due_q.push_back(cyc + LAT);
        end
        if (wa) sq.push_back(d);
        mlevel += int'(wa) - 8 * int'(ra);
        @(posedge clk);
        #1;
        cyc++;
        wr_en = 1'b0; rd_en = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            last_exp = exp_q.pop_front();
        end
        check("rd_data", rd_data, last_exp);
        check_state();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_full"}, 128'(wr_full), 128'(0));
        check({tag, "_almost_full"}, 128'(almost_full), 128'(0));
        check({tag, "_wr_level"}, 128'(wr_water_level), 128'(0));
        check({tag, "_rd_empty"}, 128'(rd_empty), 128'(1));
        check({tag, "_almost_empty"}, 128'(almost_empty), 128'(1));
        check({tag, "_rd_level"}, 128'(rd_water_level), 128'(0));
        check({tag, "_rd_data"}, rd_data, 128'(0));
    endtask

    initial begin
        #200;
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) step(1'b1, 16'hFFFF - 16'(i), 1'b0);
        check("pack_rd_level", 128'(rd_water_level), 128'(1));
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < LAT; i++) step(1'b0, '0, 1'b0);
        check("pack_word", rd_data, 128'hFFF8FFF9FFFAFFFBFFFCFFFDFFFEFFFF);

        for (int i = 0; i < 8193; i++) step(1'b1, 16'($urandom), 1'b0);
        check("fill_wr_level", 128'(wr_water_level), 128'(8192));
        check("fill_rd_level", 128'(rd_water_level), 128'(1024));
        check("fill_full", 128'(wr_full), 128'(1));

        for (int i = 0; i < 1025; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < LAT; i++) step(1'b0, '0, 1'b0);
        check("drain_empty", 128'(rd_empty), 128'(1));
        check("drain_pending", 128'(exp_q.size()), 128'(0));

        for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom), 1'b0);
        step(1'b1, 16'h1234, 1'b1);
        check("simul_level", 128'(wr_water_level), 128'(9));
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < LAT; i++) step(1'b0, '0, 1'b0);

        for (int i = 0; i < 4096; i++) step(1'b1, 16'($urandom), 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk) rst = 1'b0;
        sq.delete(); exp_q.delete(); due_q.delete();
        mlevel = 0; last_exp = '0;

        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'hA000 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < LAT; i++) step(1'b0, '0, 1'b0);
        check("post_reset_word", rd_data, 128'hA007A006A005A004A003A002A001A000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
